// File: rtl/pipe_pkg.sv
// Shared fetch-path constants and the default-width fetch entry type.
// Combinational definitions only, no latency.
// No flow control lives here.
package pipe_pkg;

  localparam int ILEN = 32;
  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

  // Default core address width; the fetch entry below is the view decode sees.
  localparam int XLEN_DFLT = 32;

  typedef struct packed {
    logic [XLEN_DFLT-1:0] pc;
    logic [ILEN-1:0]      instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous circular queue of fetch entries with flush and occupancy count.
// A push becomes visible at the head one cycle later; there is no empty bypass.
// Pop is ignored when empty; the producer must never push into a full queue without a pop.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64,
  parameter logic [WIDTH-1:0] EMPTY_VAL = '0,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic             head_vld_o,
  output logic [WIDTH-1:0] head_dat_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Next pointers and count; flush wins over any push or pop.
  always_comb begin
    do_pop   = pop_i & (count_q != '0);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CW'(push_i) - CW'(do_pop);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are don't-care until counted valid.
  always_ff @(posedge clk) begin
    if (!rst && push_i && !flush_i) begin
      mem_q[wr_ptr_q] <= push_dat_i;
    end
  end

  // Overflow guard: a push into a full queue needs a matching pop.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push_i && !flush_i && !do_pop && count_q == CW'(DEPTH)));
    end
  end

  assign head_vld_o = (count_q != '0);
  assign head_dat_o = head_vld_o ? mem_q[rd_ptr_q] : EMPTY_VAL;
  assign count_o    = count_q;

endmodule

// File: rtl/fetch_buffer.sv
// Instruction fetch: PC generator, fixed-latency IMEM request tracking, {pc,instr} queue to decode.
// Request at cycle t is visible to decode at t+MEM_LAT+1; a redirect at r issues its first request at r+1.
// Requests are credit-limited so queue plus in-flight never exceeds DEPTH; responses are never dropped.
module fetch_buffer
  import pipe_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int DEPTH = 4,
  parameter int MEM_LAT = 1,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  localparam int FLW = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [ILEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [ILEN-1:0] id_instr,
  output logic [FLW-1:0]  fill_level
);

  localparam int IFW  = $clog2(MEM_LAT + 1);
  localparam int SUMW = $clog2(DEPTH + MEM_LAT + 1) + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } entry_t;

  localparam entry_t EMPTY_ENTRY = '{pc: '0, instr: NOP_INSTR};

  logic [XLEN-1:0]    pc_q, pc_d;
  logic [MEM_LAT-1:0] slot_vld_q, slot_vld_d;
  logic [XLEN-1:0]    slot_pc_q [MEM_LAT];
  logic [XLEN-1:0]    slot_pc_d [MEM_LAT];
  logic [IFW-1:0]     inflight_q, inflight_d;
  logic               resp_vld;
  logic               push;
  logic               credit_ok;
  entry_t             push_entry;
  entry_t             head_entry;
  logic               redirect_lsb_unused;

  // Target is word aligned; the low bits are deliberately dropped.
  assign redirect_lsb_unused = ^redirect_pc[1:0];

  assign resp_vld = slot_vld_q[MEM_LAT-1];
  // A response landing in the redirect cycle belongs to the dead path.
  assign push     = resp_vld & ~redirect_valid;

  // Credit uses pre-edge counts, so a pop this cycle frees nothing until next cycle.
  assign credit_ok = (SUMW'(fill_level) + SUMW'(inflight_q)) < SUMW'(DEPTH);
  assign imem_req  = ~rst & ~redirect_valid & credit_ok;
  assign imem_addr = pc_q;

  // PC, in-flight tracking and counter next state; redirect kills everything older.
  always_comb begin
    pc_d       = pc_q;
    inflight_d = inflight_q;
    slot_vld_d = slot_vld_q;
    for (int i = 0; i < MEM_LAT; i++) slot_pc_d[i] = slot_pc_q[i];

    slot_vld_d[0] = imem_req;
    slot_pc_d[0]  = pc_q;
    for (int i = 1; i < MEM_LAT; i++) begin
      slot_vld_d[i] = slot_vld_q[i-1];
      slot_pc_d[i]  = slot_pc_q[i-1];
    end

    if (redirect_valid) begin
      pc_d       = {redirect_pc[XLEN-1:2], 2'b00};
      slot_vld_d = '0;
      inflight_d = '0;
    end else begin
      if (imem_req) pc_d = pc_q + XLEN'(4);
      inflight_d = inflight_q + IFW'(imem_req) - IFW'(resp_vld);
    end
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      slot_vld_q <= '0;
      inflight_q <= '0;
    end else begin
      pc_q       <= pc_d;
      slot_vld_q <= slot_vld_d;
      inflight_q <= inflight_d;
    end
  end

  // In-flight PCs travel alongside their valid bits; no reset needed.
  always_ff @(posedge clk) begin
    for (int i = 0; i < MEM_LAT; i++) slot_pc_q[i] <= slot_pc_d[i];
  end

  // Counter range guards and in-flight bookkeeping consistency.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (inflight_q <= IFW'(MEM_LAT));
      assert (inflight_q == IFW'($countones(slot_vld_q)));
      assert (!(resp_vld && inflight_q == '0));
      assert (fill_level <= FLW'(DEPTH));
    end
  end

  assign push_entry = '{pc: slot_pc_q[MEM_LAT-1], instr: imem_rdata};

  fetch_fifo #(
    .DEPTH     (DEPTH),
    .WIDTH     (XLEN + ILEN),
    .EMPTY_VAL (EMPTY_ENTRY)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push),
    .push_dat_i (push_entry),
    .pop_i      (id_ready),
    .flush_i    (redirect_valid),
    .head_vld_o (id_valid),
    .head_dat_o (head_entry),
    .count_o    (fill_level)
  );

  assign id_pc    = head_entry.pc;
  assign id_instr = head_entry.instr;

endmodule
